// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the APB master arbiter: FSM states and the slave address map.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_DERR
  } state_t;

  localparam int unsigned REGION_TAG_W = 6;

  localparam logic [REGION_TAG_W-1:0] REGION_S0 = 6'b100000;
  localparam logic [REGION_TAG_W-1:0] REGION_S1 = 6'b100001;
  localparam logic [REGION_TAG_W-1:0] REGION_S2 = 6'b100010;

  localparam logic [2:0] PSEL_NONE = 3'b000;
  localparam logic [2:0] PSEL_S0   = 3'b001;
  localparam logic [2:0] PSEL_S1   = 3'b010;
  localparam logic [2:0] PSEL_S2   = 3'b100;

  function automatic logic [2:0] decode_region(input logic [REGION_TAG_W-1:0] tag);
    case (tag)
      REGION_S0: return PSEL_S0;
      REGION_S1: return PSEL_S1;
      REGION_S2: return PSEL_S2;
      default:   return PSEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the shared master port and the APB slaves.
interface apb_master_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic [2:0]        Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic [DATA_W-1:0] Prdata;
  logic              Pready;
  logic              Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin requester selection: search starts at the pointer and wraps; pointer moves past each winner.
module apb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters with RR arbitration and address decode.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_bridge_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      Hclk,
  input  logic                      Hreset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic [DATA_W-1:0]         req_rdata,
  apb_master_arbiter_if.master      apb
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit watchdog");
  end

  state_t state, state_nx;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [2:0]         sel_psel;

  logic [NUM_REQ-1:0] gnt_oh;
  logic               lat_write;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [2:0]         lat_sel;
  logic               lat_err;
  logic [DATA_W-1:0]  rdata_q;
  logic               timeout_hit;
  logic               apb_active;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk         (Hclk),
    .rst         (Hreset),
    .req         (req),
    .advance     (state == ST_IDLE),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
    sel_psel = decode_region(sel_addr[ADDR_W-1 -: REGION_TAG_W]);
  end

`ifdef APB_TIMEOUT_EN
  logic [7:0] wdog;

  // Cleared throughout SETUP so every transfer's ACCESS phase starts counting from zero.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      wdog <= '0;
    end else if (state == ST_SETUP) begin
      wdog <= '0;
    end else if (state == ST_ACCESS && !apb.Pready) begin
      wdog <= wdog + 1'b1;
    end
  end

  assign timeout_hit = (state == ST_ACCESS) && !apb.Pready && (wdog == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (arb_valid) state_nx = (sel_psel == PSEL_NONE) ? ST_DERR : ST_SETUP;
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: if (apb.Pready || timeout_hit) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      ST_DERR:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    apb_active  = (state == ST_SETUP) || (state == ST_ACCESS);
    apb.Pselx   = apb_active ? lat_sel : PSEL_NONE;
    apb.Penable = (state == ST_ACCESS);
    apb.Pwrite  = apb_active ? lat_write : 1'b0;
    apb.Paddr   = apb_active ? lat_addr : '0;
    apb.Pwdata  = apb_active ? lat_wdata : '0;
    req_done    = (state == ST_DONE || state == ST_DERR) ? gnt_oh : '0;
    req_err     = (state == ST_DERR) || (state == ST_DONE && lat_err);
    req_rdata   = rdata_q;
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state     <= ST_IDLE;
      gnt_oh    <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_sel   <= PSEL_NONE;
      lat_err   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && arb_valid) begin
        gnt_oh    <= arb_grant;
        lat_write <= sel_write;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_sel   <= sel_psel;
        if (sel_psel == PSEL_NONE) rdata_q <= '0;
      end
      if (state == ST_ACCESS) begin
        if (apb.Pready) begin
          rdata_q <= apb.Prdata;
          lat_err <= apb.Pslverr;
        end else if (timeout_hit) begin
          rdata_q <= '0;
          lat_err <= 1'b1;
        end
      end
    end
  end

endmodule
